// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate arbiter: operation encodings and
// default datapath sizing.
package shift_pkg;

   localparam int SHIFT_WIDTH = 16;
   localparam int SHIFT_CNT_W = 4;

   localparam logic [1:0] SHOP_ROL = 2'b00;
   localparam logic [1:0] SHOP_SLL = 2'b01;
   localparam logic [1:0] SHOP_ROR = 2'b10;
   localparam logic [1:0] SHOP_SRL = 2'b11;

   typedef struct packed {
      logic right;
      logic logical;
   } shop_dec_t;

   // Bit 1 selects direction, bit 0 selects zero fill instead of wrap.
   function automatic shop_dec_t shop_decode(input logic [1:0] op);
      shop_dec_t d;
      d.right   = op[1];
      d.logical = op[0];
      return d;
   endfunction

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational four-operation shifter built as log2(WIDTH) mux stages,
// largest step first (8/4/2/1 for a 16-bit datapath).
module shifter
   import shift_pkg::*;
#(
   parameter int WIDTH = SHIFT_WIDTH,
   parameter int CNT_W = SHIFT_CNT_W
) (
   input  logic [WIDTH-1:0] in_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic [1:0]       op_i,
   output logic [WIDTH-1:0] out_o
);

   shop_dec_t       dec;
   logic [WIDTH-1:0] stage_data [0:CNT_W];

   assign dec           = shop_decode(op_i);
   assign stage_data[0] = in_i;

   genvar gi;
   generate
      for (gi = 0; gi < CNT_W; gi++) begin : g_stage
         localparam int SH = 1 << (CNT_W - 1 - gi);

         logic [SH-1:0]    fill_left;
         logic [SH-1:0]    fill_right;
         logic [WIDTH-1:0] shl;
         logic [WIDTH-1:0] shr;

         // Wrapped bits for rotates, zeros for logical shifts.
         assign fill_left  = dec.logical ? '0 : stage_data[gi][WIDTH-1 -: SH];
         assign fill_right = dec.logical ? '0 : stage_data[gi][SH-1:0];
         assign shl        = {stage_data[gi][WIDTH-SH-1:0], fill_left};
         assign shr        = {fill_right, stage_data[gi][WIDTH-1:SH]};

         assign stage_data[gi+1] = cnt_i[CNT_W-1-gi] ? (dec.right ? shr : shl)
                                                     : stage_data[gi];
      end
   endgenerate

   assign out_o = stage_data[CNT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Two-port round-robin front end for a shared 16-bit shifter with a one-entry
// valid/ready result buffer.
module shift_arbiter
   import shift_pkg::*;
#(
   parameter int WIDTH = SHIFT_WIDTH,
   parameter int CNT_W = SHIFT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [1:0]       op0,
   input  logic [WIDTH-1:0] in0,
   input  logic [CNT_W-1:0] cnt0,
   input  logic             req1,
   input  logic [1:0]       op1,
   input  logic [WIDTH-1:0] in1,
   input  logic [CNT_W-1:0] cnt1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_id
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             out_id_q,    out_id_d;
   logic             last_id_q,   last_id_d;

   logic             can_accept;
   logic             grant_any;
   logic             sel_id;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_in;
   logic [CNT_W-1:0] sel_cnt;
   logic [WIDTH-1:0] shift_result;

   // Accepting while the buffer drains in the same cycle keeps throughput at one per cycle.
   assign can_accept = !out_valid_q || out_ready;

   // On a tie the requester that was not granted last wins.
   assign gnt0 = !rst && can_accept && req0 && (!req1 || last_id_q);
   assign gnt1 = !rst && can_accept && req1 && (!req0 || !last_id_q);

   assign grant_any = gnt0 || gnt1;
   assign sel_id    = gnt1;

   always_comb begin
      sel_op  = op0;
      sel_in  = in0;
      sel_cnt = cnt0;
      if (sel_id) begin
         sel_op  = op1;
         sel_in  = in1;
         sel_cnt = cnt1;
      end
   end

   shifter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_shifter (
      .in_i  (sel_in),
      .cnt_i (sel_cnt),
      .op_i  (sel_op),
      .out_o (shift_result)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      last_id_d   = last_id_q;
      if (grant_any) begin
         out_valid_d = 1'b1;
         out_data_d  = shift_result;
         out_id_d    = sel_id;
         last_id_d   = sel_id;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= 1'b0;
         last_id_q   <= 1'b1;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         last_id_q   <= last_id_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: shifter ops, round-robin ties,
// backpressure, reset mid-operation and lone-requester throughput.
module tb_shift_arbiter;
   import shift_pkg::*;

   localparam int W  = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1;
   logic [1:0]    op0, op1;
   logic [W-1:0]  in0, in1;
   logic [CW-1:0] cnt0, cnt1;
   logic          gnt0, gnt1;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          out_id;

   int total = 0;
   int bad   = 0;

   shift_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .op0       (op0),
      .in0       (in0),
      .cnt0      (cnt0),
      .req1      (req1),
      .op1       (op1),
      .in1       (in1),
      .cnt1      (cnt1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      $display("check %-14s observed=%h expected=%h", tag, obs, exp);
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [1:0]    tbl_op  [8] = '{SHOP_ROL, SHOP_SLL, SHOP_ROR, SHOP_SRL,
                                  SHOP_ROL, SHOP_SLL, SHOP_ROR, SHOP_SRL};
   logic [CW-1:0] tbl_cnt [8] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
   logic [W-1:0]  tbl_exp [8] = '{16'h00FF, 16'h00F0, 16'hFF00, 16'h0F00,
                                  16'hF00F, 16'hF00F, 16'hF00F, 16'hF00F};
   logic [W-1:0]  lone_exp [4] = '{16'h0002, 16'h0004, 16'h0008, 16'h0010};

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
      op0 = '0; op1 = '0; in0 = '0; in1 = '0; cnt0 = '0; cnt1 = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, 16'h0000);
      check("rst_id", out_id, 1'b0);
      check("rst_gnt0", gnt0, 1'b0);
      check("rst_gnt1", gnt1, 1'b0);

      // First transaction: ROL 8001 by 1
      tick();
      req0 = 1'b1; op0 = SHOP_ROL; in0 = 16'h8001; cnt0 = 4'd1; out_ready = 1'b1;
      #1;
      check("first_gnt0", gnt0, 1'b1);
      check("first_gnt1", gnt1, 1'b0);
      tick();
      req0 = 1'b0;
      check("first_valid", out_valid, 1'b1);
      check("first_data", out_data, 16'h0003);
      check("first_id", out_id, 1'b0);

      // All four ops, cnt 4 and cnt 0
      for (int k = 0; k < 8; k++) begin
         req0 = 1'b1; op0 = tbl_op[k]; in0 = 16'hF00F; cnt0 = tbl_cnt[k];
         #1;
         check("op_gnt0", gnt0, 1'b1);
         tick();
         check("op_data", out_data, tbl_exp[k]);
      end
      req0 = 1'b0;
      tick();
      check("idle_drain", out_valid, 1'b0);

      // Fresh reset, then a 4-cycle tie alternates starting with port 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0 = 1'b1; op0 = SHOP_SLL; in0 = 16'h0001; cnt0 = 4'd1;
      req1 = 1'b1; op1 = SHOP_SLL; in1 = 16'h0100; cnt1 = 4'd2;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("tie_gnt0", gnt0, (k % 2 == 0) ? 1'b1 : 1'b0);
         check("tie_gnt1", gnt1, (k % 2 == 1) ? 1'b1 : 1'b0);
         tick();
         check("tie_id", out_id, (k % 2 == 1) ? 1'b1 : 1'b0);
         check("tie_data", out_data, (k % 2 == 1) ? 16'h0400 : 16'h0002);
      end

      // Backpressure: 0400 from port 1 pending, new port 1 request must wait
      req0 = 1'b0; out_ready = 1'b0;
      req1 = 1'b1; op1 = SHOP_ROR; in1 = 16'hF00F; cnt1 = 4'd4;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_gnt1", gnt1, 1'b0);
         tick();
         check("bp_valid", out_valid, 1'b1);
         check("bp_data", out_data, 16'h0400);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release", gnt1, 1'b1);
      tick();
      check("bp_new_data", out_data, 16'hFF00);
      check("bp_new_id", out_id, 1'b1);
      check("bp_new_valid", out_valid, 1'b1);

      // Reset the cycle after a grant, with a request still high
      rst = 1'b1;
      #1;
      check("rst_gnt_forced", gnt1, 1'b0);
      tick();
      rst = 1'b0;
      check("rstmid_valid", out_valid, 1'b0);
      check("rstmid_data", out_data, 16'h0000);
      req0 = 1'b1; op0 = SHOP_ROL; in0 = 16'h8001; cnt0 = 4'd1;
      #1;
      check("rstmid_tie_g0", gnt0, 1'b1);
      check("rstmid_tie_g1", gnt1, 1'b0);
      tick();
      check("rstmid_tie_id", out_id, 1'b0);
      check("rstmid_tie_dat", out_data, 16'h0003);

      // Lone port 1 requester streams without bubbles
      req0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         req1 = 1'b1; op1 = SHOP_SLL; in1 = 16'h0001; cnt1 = 4'(k + 1);
         #1;
         check("lone_gnt1", gnt1, 1'b1);
         tick();
         check("lone_valid", out_valid, 1'b1);
         check("lone_id", out_id, 1'b1);
         check("lone_data", out_data, lone_exp[k]);
      end
      req1 = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 16-bit shift/rotate datapath between two requesters: typically the execute-stage ALU path (port 0) and the multi-cycle/debug path (port 1). A round-robin arbiter accepts at most one operation per cycle and issues it to a combinational shifter. The result is registered in a one-entry output buffer with valid/ready backpressure. The block sits beside the ALU in the execute stage and replaces per-requester shifter instances.

## Interface
- WIDTH, 16, data width; must be a power of two
- CNT_W, 4, shift-count width, log2(WIDTH)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  request valid; held high with stable operands until granted
- op0 / op1  in  2  operation: 00 rotate left, 01 shift left logical, 10 rotate right, 11 shift right logical
- in0 / in1  in  WIDTH  operand
- cnt0 / cnt1  in  CNT_W  shift amount, 0..WIDTH-1
- gnt0 / gnt1  out  1  combinational accept, same cycle as request; at most one high
- out_valid  out  1  result buffer holds a result
- out_ready  in  1  consumer takes result this cycle when out_valid
- out_data  out  WIDTH  shifted result
- out_id  out  1  requester that produced out_data (0 or 1)

## Operation
- Two state elements: result buffer (out_valid, out_data, out_id) and priority pointer last_id (1 bit, id of last granted requester).
- can_accept = !out_valid | out_ready (buffer empty or draining this cycle).
- Grant, combinational:
  - if !can_accept: no grant
  - else if exactly one reqN: grant it
  - else if both: grant requester != last_id
- On grant of N at an edge:
  - out_data <= shift(opN, inN, cntN); out_id <= N; out_valid <= 1; last_id <= N
- No grant and out_ready & out_valid: out_valid <= 0; out_data/out_id hold.
- last_id changes only on a grant; an idle cycle does not move priority.
- Shift rules, all results WIDTH bits:
  - rotate: bits wrap
  - logical shifts: zero fill
  - cnt 0 returns the operand unchanged for every op
- gnt with req low is illegal and never produced. Operands are sampled only in the grant cycle.

## Timing
- Reset values:
  - out_valid 0, out_data 0, out_id 0, last_id 1 (port 0 wins first tie)
  - gnt0/gnt1 follow the grant equation, which is 0 while out_valid is 0 and no req is high
- Latency: grant in cycle N, result visible with out_valid=1 in cycle N+1.
- Throughput: one op per cycle while out_ready stays high. Simultaneous accept and drain in the same cycle is the normal case and loses no bubble.
- Backpressure: out_valid & !out_ready → no grants; out_data/out_id are stable until consumed.
- Requester dropping req before grant: permitted, treated as withdrawn; no state change.
- rst asserted mid-operation: buffer cleared and any pending result discarded. gnt forced 0 in the reset cycle; requesters must re-present after reset.

## Structure
- Shared package shift_pkg:
  - op encodings SHOP_ROL=2'b00, SHOP_SLL=2'b01, SHOP_ROR=2'b10, SHOP_SRL=2'b11
  - WIDTH/CNT_W defaults
- One sub-module, shifter (In, Cnt, Op, Out): combinational four-op shifter, log2 mux stages of 8/4/2/1.
- Arbiter, operand mux and result register stay in shift_arbiter.

## Test plan
- Reset, then req0, op 00, in0=16'h8001, cnt0=1, out_ready=1 → gnt0 same cycle; next cycle out_valid=1, out_data=16'h0003, out_id=0.
- All ops with in=16'hF00F, cnt=4 → ROL 16'h00FF, SLL 16'h00F0, ROR 16'hFF00, SRL 16'h0F00; cnt=0 → 16'hF00F for all four.
- req0 and req1 both held high for 4 cycles after reset, out_ready=1 → grants 0,1,0,1; out_id sequence 0,1,0,1 one cycle later.
- out_ready=0 with result pending and req1 high for 3 cycles → gnt1 stays 0 and out_data stable. Raise out_ready → same cycle gnt1=1, old result consumed, new result valid next cycle.
- rst pulsed the cycle after a grant → out_valid=0, out_data=0 next cycle. Then a tie grants port 0 first.
- Single requester req1 continuous with out_ready=1 → gnt1 every cycle with no bubbles, proving priority does not block a lone requester.
